channel_rr_merge: RTL and testbench

CHANNEL_RR_MERGE -- requirements
Module: channel_rr_merge

---
 rtl/channel_rr_merge.sv | 87 ++++++++
 tb/tb_channel_rr_merge.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/channel_rr_merge.sv
// Round-robin merge of M valid/ack input channels into one registered output
// channel; the rotating pointer starts each search just past the last grant.
module channel_rr_merge #(
  parameter int N = 8,
  parameter int M = 4,
  localparam int IW = $clog2(M)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [M*N-1:0] in_d,
  input  logic [M-1:0]   in_v,
  output logic [M-1:0]   in_a,
  input  logic [M-1:0]   enable,
  output logic [N-1:0]   out_d,
  output logic [IW-1:0]  out_idx,
  output logic           out_v,
  input  logic           out_a
);

  // Handshake: on every channel a word moves on a rising edge where v=1 and
  // a=1; v never depends on a, and in_a is combinational from in_v/enable.

  logic [N-1:0]  r_out_d;
  logic [IW-1:0] r_out_idx;
  logic          r_out_v;
  logic [IW-1:0] r_ptr;

  logic          w_load_ok;
  logic [M-1:0]  w_elig;
  logic          w_found;
  logic [IW-1:0] w_g;
  logic          w_grant;
  logic [N-1:0]  w_sel_d;

  assign w_load_ok = !r_out_v || out_a;
  assign w_elig    = in_v & enable;

  // Search upward from r_ptr with wrap; candidate kept one bit wider so the
  // wrap subtraction works for non-power-of-two M.
  always_comb begin
    logic [IW:0] w_cand;
    w_found = 1'b0;
    w_g     = '0;
    w_cand  = '0;
    for (int k = 0; k < M; k++) begin
      w_cand = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_cand >= (IW+1)'(M)) begin
        w_cand = w_cand - (IW+1)'(M);
      end
      if (!w_found && w_elig[w_cand[IW-1:0]]) begin
        w_found = 1'b1;
        w_g     = w_cand[IW-1:0];
      end
    end
  end

  assign w_grant = !reset && w_load_ok && w_found;
  assign w_sel_d = in_d[w_g*N +: N];

  always_comb begin
    in_a = '0;
    if (w_grant) begin
      in_a[w_g] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_v   <= 1'b0;
      r_out_d   <= '0;
      r_out_idx <= '0;
      r_ptr     <= '0;
    end else if (w_grant) begin
      r_out_v   <= 1'b1;
      r_out_d   <= w_sel_d;
      r_out_idx <= w_g;
      r_ptr     <= (w_g == IW'(M-1)) ? '0 : w_g + 1'b1;
    end else if (w_load_ok) begin
      r_out_v   <= 1'b0;
    end
  end

  assign out_d   = r_out_d;
  assign out_idx = r_out_idx;
  assign out_v   = r_out_v;

endmodule

// File: tb/tb_channel_rr_merge.sv
// Directed bench for channel_rr_merge (M=4, N=8) with a short random
// scoreboard tail checking ordering, one-hot acks and word conservation.
module tb_channel_rr_merge;

  localparam int N = 8;
  localparam int M = 4;

  logic         clk;
  logic         reset;
  logic [31:0]  in_d;
  logic [3:0]   in_v;
  logic [3:0]   in_a;
  logic [3:0]   enable;
  logic [7:0]   out_d;
  logic [1:0]   out_idx;
  logic         out_v;
  logic         out_a;

  int n_vec = 0;
  int n_err = 0;

  logic [9:0] exp_q[$];

  channel_rr_merge #(.N(N), .M(M)) dut (
    .clk(clk), .reset(reset), .in_d(in_d), .in_v(in_v), .in_a(in_a),
    .enable(enable), .out_d(out_d), .out_idx(out_idx), .out_v(out_v),
    .out_a(out_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] idx, input logic [7:0] d);
    chk({tag, "_v"}, {31'd0, out_v}, {31'd0, v});
    chk({tag, "_idx"}, {30'd0, out_idx}, {30'd0, idx});
    chk({tag, "_d"}, {24'd0, out_d}, {24'd0, d});
  endtask

  initial begin
    int t1[5];
    int t4[4];
    int gi;
    logic [9:0] w;
    t1 = '{0, 1, 2, 3, 0};
    t4 = '{1, 3, 1, 3};

    // Reset: in_a must stay low while reset is high even with requests.
    reset = 1'b1; in_v = 4'hF; enable = 4'hF; out_a = 1'b1; in_d = 32'h13121110;
    #1;
    chk("rst_in_a", {28'd0, in_a}, 32'h0);
    tick();
    chk_out("rst", 1'b0, 2'd0, 8'h00);
    chk("rst_in_a_hold", {28'd0, in_a}, 32'h0);

    // Full-rate rotation over all inputs.
    reset = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("rr_in_a", {28'd0, in_a}, 32'd1 << t1[i]);
      tick();
      chk_out("rr", 1'b1, t1[i][1:0], 8'h10 + 8'(t1[i]));
    end

    // Drain, then single requester with output stalled for three cycles.
    in_v = 4'h0; out_a = 1'b1;
    tick();
    chk("drain_v", {31'd0, out_v}, 32'd0);
    in_d = 32'h13A51110; in_v = 4'b0100; out_a = 1'b0;
    #1;
    chk("stall_grant", {28'd0, in_a}, 32'h4);
    tick();
    chk_out("stall_load", 1'b1, 2'd2, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_a", {28'd0, in_a}, 32'h0);
      tick();
      chk_out("stall_hold", 1'b1, 2'd2, 8'hA5);
    end
    out_a = 1'b1;
    #1;
    chk("stall_release", {28'd0, in_a}, 32'h4);
    tick();
    chk_out("stall_next", 1'b1, 2'd2, 8'hA5);

    // Pointer now 3: requests on 0 and 3 must go 3 then wrap to 0.
    in_d = 32'h13121110; in_v = 4'b1001;
    #1;
    chk("wrap_g3", {28'd0, in_a}, 32'h8);
    tick();
    chk_out("wrap3", 1'b1, 2'd3, 8'h13);
    chk("wrap_g0", {28'd0, in_a}, 32'h1);
    tick();
    chk_out("wrap0", 1'b1, 2'd0, 8'h10);

    // Enable mask 1010 with all requesting: 1,3,1,3.
    in_v = 4'hF; enable = 4'b1010;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("mask_in_a", {28'd0, in_a}, 32'd1 << t4[i]);
      tick();
      chk_out("mask", 1'b1, t4[i][1:0], 8'h10 + 8'(t4[i]));
    end

    // Dropping enable while the output is held must not retract the word.
    out_a = 1'b0; enable = 4'h0;
    #1;
    chk("en_drop_in_a", {28'd0, in_a}, 32'h0);
    tick();
    chk_out("en_drop", 1'b1, 2'd3, 8'h13);

    // Grant 0 to move pointer to 1, then stall and reset mid-hold.
    enable = 4'hF; in_v = 4'b0001; out_a = 1'b1;
    tick();
    chk_out("pre_rst", 1'b1, 2'd0, 8'h10);
    in_v = 4'b0101; out_a = 1'b0; reset = 1'b1;
    #1;
    chk("mid_rst_in_a", {28'd0, in_a}, 32'h0);
    tick();
    chk_out("mid_rst", 1'b0, 2'd0, 8'h00);
    out_a = 1'b1;
    #1;
    chk("rst_force_in_a", {28'd0, in_a}, 32'h0);
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_grant", {28'd0, in_a}, 32'h1);
    tick();
    chk_out("post_rst", 1'b1, 2'd0, 8'h10);

    // Random tail: drain first so the scoreboard starts empty.
    in_v = 4'h0;
    tick();
    for (int c = 0; c < 400; c++) begin
      in_v   = 4'($urandom_range(0, 15));
      enable = 4'($urandom_range(0, 15));
      out_a  = 1'($urandom_range(0, 1));
      in_d   = $urandom;
      #1;
      chk("rnd_onehot", {31'd0, $onehot0(in_a)}, 32'd1);
      chk("rnd_ack_elig", {28'd0, in_a & ~(in_v & enable)}, 32'h0);
      if (out_v && out_a) begin
        chk("rnd_q_depth", exp_q.size(), 32'd1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          chk("rnd_word", {22'd0, out_idx, out_d}, {22'd0, w});
        end
      end
      if (in_a != 4'h0) begin
        gi = 0;
        for (int i = 0; i < 4; i++) if (in_a[i]) gi = i;
        exp_q.push_back({2'(gi), in_d[gi*8 +: 8]});
      end
      tick();
    end
    in_v = 4'h0; out_a = 1'b1;
    #1;
    if (out_v) begin
      w = exp_q.pop_front();
      chk("rnd_last", {22'd0, out_idx, out_d}, {22'd0, w});
    end
    tick();
    chk("rnd_q_empty", exp_q.size(), 32'd0);
    chk("rnd_idle_v", {31'd0, out_v}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
